// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two ALU requesters and alu_arbiter.
// A request or response transfers on a rising edge where both valid and ready are high. The slave side drives the ready and response signals.
interface alu_arbiter_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [2:0] req0_op;
  logic [7:0] req0_a;
  logic [7:0] req0_b;
  logic       req1_valid;
  logic       req1_ready;
  logic [2:0] req1_op;
  logic [7:0] req1_a;
  logic [7:0] req1_b;
  logic       rsp0_valid;
  logic       rsp0_ready;
  logic       rsp1_valid;
  logic       rsp1_ready;
  logic [7:0] rsp_data;
  logic       rsp_zero;
  logic       rsp_div0;
  logic       rsp_inval;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_data, rsp_zero, rsp_div0, rsp_inval
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_data, rsp_zero, rsp_div0, rsp_inval
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port round-robin sequencer for the shared combinational 8-bit ALU.
// It accepts one request, runs it for one EXEC cycle, and holds the response until it is consumed.
module alu_arbiter (
    input  logic               clk,
    input  logic               reset,
    alu_arbiter_if.slave       bus,
    output logic [7:0]         alu_operand1,
    output logic [7:0]         alu_operand2,
    output logic [2:0]         alu_operation,
    output logic               alu_enable,
    input  logic [7:0]         alu_result,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state;
    logic       last_grant;
    logic       grant;
    logic       pick0;
    logic       pick1;
    logic [2:0] sel_op;
    logic [7:0] sel_a;
    logic [7:0] sel_b;
    logic       exec_div0;
    logic       exec_inval;
    logic [7:0] exec_data;
    logic       rsp_done;

    // On a tie, the requester that was not served last wins.
    always_comb begin
        pick0 = bus.req0_valid && (!bus.req1_valid || last_grant);
        pick1 = bus.req1_valid && (!bus.req0_valid || !last_grant);
        sel_op = pick1 ? bus.req1_op : bus.req0_op;
        sel_a  = pick1 ? bus.req1_a  : bus.req0_a;
        sel_b  = pick1 ? bus.req1_b  : bus.req0_b;
    end

    always_comb begin
        exec_div0  = (alu_operation == 3'b011) && (alu_operand2 == 8'h00);
        exec_inval = (alu_operation == 3'b111);
        exec_data  = (exec_div0 || exec_inval) ? 8'h00 : alu_result;
        rsp_done   = grant ? bus.rsp1_ready : bus.rsp0_ready;
    end

    assign bus.req0_ready = (state == IDLE) && !reset && pick0;
    assign bus.req1_ready = (state == IDLE) && !reset && pick1;
    assign dbg_state      = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            last_grant     <= 1'b1;
            grant          <= 1'b0;
            alu_operand1   <= 8'h00;
            alu_operand2   <= 8'h00;
            alu_operation  <= 3'b000;
            alu_enable     <= 1'b0;
            bus.rsp0_valid <= 1'b0;
            bus.rsp1_valid <= 1'b0;
            bus.rsp_data   <= 8'h00;
            bus.rsp_zero   <= 1'b0;
            bus.rsp_div0   <= 1'b0;
            bus.rsp_inval  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick0 || pick1) begin
                        grant         <= pick1;
                        last_grant    <= pick1;
                        alu_operation <= sel_op;
                        alu_operand1  <= sel_a;
                        alu_operand2  <= sel_b;
                        // The ALU is never enabled for an invalid opcode or a divide by zero.
                        alu_enable    <= !((sel_op == 3'b111) ||
                                           ((sel_op == 3'b011) && (sel_b == 8'h00)));
                        state         <= EXEC;
                    end
                end
                EXEC: begin
                    alu_enable     <= 1'b0;
                    bus.rsp_data   <= exec_data;
                    bus.rsp_zero   <= (exec_data == 8'h00);
                    bus.rsp_div0   <= exec_div0;
                    bus.rsp_inval  <= exec_inval;
                    bus.rsp0_valid <= !grant;
                    bus.rsp1_valid <= grant;
                    state          <= RESP;
                end
                RESP: begin
                    if (rsp_done) begin
                        bus.rsp0_valid <= 1'b0;
                        bus.rsp1_valid <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
